// File: rtl/gnn_pkg.sv
// Shared types and constants for the GNN node aggregation path.
package gnn_pkg;

    // Width of each signed score produced by the per-node MAC stage.
    localparam int MAC_OUT_W = 17;

    // Default accumulator/result width of the aggregator.
    localparam int AGG_ACC_W = 18;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } agg_state_e;

    // Result entry at the default accumulator width. node_aggregator declares a
    // layout-identical entry_t sized by its own ACC_W parameter.
    typedef struct packed {
        logic signed [AGG_ACC_W-1:0] sum0;
        logic signed [AGG_ACC_W-1:0] sum1;
        logic                        cls;
    } agg_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted when a pop happens in
// the same cycle, because the slot being written is the head being popped.
// The head is presented combinationally on dout.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/node_aggregator.sv
// Sums NUM_NEIGH consecutive MAC score pairs into one node result, derives a
// class bit (sum1 > sum0) and queues results for the write-back stage.
// Optional: define AGG_SATURATE_EN to clamp every add to the ACC_W signed
// range; otherwise adds wrap in two's complement.
module node_aggregator
    import gnn_pkg::*;
#(
    parameter int NUM_NEIGH = 4,
    parameter int ACC_W     = AGG_ACC_W,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [MAC_OUT_W-1:0] in0,
    input  logic [MAC_OUT_W-1:0] in1,
    input  logic                 flush,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     res_sum0,
    output logic [ACC_W-1:0]     res_sum1,
    output logic                 res_cls,
    output logic                 overflow,
    output logic                 busy
);

    localparam int CNT_W = (NUM_NEIGH > 1) ? $clog2(NUM_NEIGH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEIGH - 1);

    typedef struct packed {
        logic signed [ACC_W-1:0] sum0;
        logic signed [ACC_W-1:0] sum1;
        logic                    cls;
    } entry_t;

    localparam int EW = $bits(entry_t);

`ifdef AGG_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // One accumulation step, clamped or wrapping depending on the build.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
`ifdef AGG_SATURATE_EN
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? SMIN : SMAX;
        return s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    agg_state_e              state, state_nx;
    logic signed [ACC_W-1:0] acc0, acc1;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] in0_x, in1_x;
    logic signed [ACC_W-1:0] sum0_nx, sum1_nx;
    logic                    accept, complete, pop;
    logic                    fifo_full, fifo_empty;
    entry_t                  push_ent, head_ent;
    logic [EW-1:0]           head_bits;

    assign in0_x    = ACC_W'($signed(in0));
    assign in1_x    = ACC_W'($signed(in1));
    assign sum0_nx  = acc_add(acc0, in0_x);
    assign sum1_nx  = acc_add(acc1, in1_x);

    // flush beats a coincident sample, including the one that would complete.
    assign accept   = in_valid & ~flush;
    assign complete = accept & (cnt == LAST);
    assign pop      = res_valid & res_ready;

    assign push_ent.sum0 = sum0_nx;
    assign push_ent.sum1 = sum1_nx;
    assign push_ent.cls  = (sum1_nx > sum0_nx);

    // Group state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state: a group opens on a non-completing sample, closes on completion or flush.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !complete) state_nx = ACCUM;
            ACCUM:   if (flush || complete)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Running sums and sample count; cleared on completion even if the result is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush || complete) begin
            acc0 <= '0;
            acc1 <= '0;
            cnt  <= '0;
        end else if (accept) begin
            acc0 <= sum0_nx;
            acc1 <= sum1_nx;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Sticky drop flag: a completed result found the FIFO full with no pop.
    always_ff @(posedge clk) begin
        if (rst)                                overflow <= 1'b0;
        else if (complete && fifo_full && !pop) overflow <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (complete),
        .pop   (pop),
        .din   (push_ent),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields are forced to zero while empty so stale storage never shows.
    assign head_ent  = head_bits;
    assign res_valid = ~fifo_empty;
    assign res_sum0  = fifo_empty ? '0 : head_ent.sum0;
    assign res_sum1  = fifo_empty ? '0 : head_ent.sum1;
    assign res_cls   = fifo_empty ? 1'b0 : head_ent.cls;
    assign busy      = (state == ACCUM);

endmodule
